// File: rtl/cell_cache.sv
// Per-core write-back, lockable tape-cell cache over the shared tape memory.
// Lookups resolve combinationally; misses, evictions and drains run one at a time on the memory port.
module cell_cache #(
    parameter int NENTRIES = 4,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_lock,
    input  logic              flush,
    output logic              rd_hit,
    output logic [DATA_W-1:0] rd_data,
    output logic              stall,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              drain,
    output logic              drain_done
);
    localparam int IDX_W = (NENTRIES > 1) ? $clog2(NENTRIES) : 1;

    typedef enum logic [2:0] {IDLE, EVICT, FILL, WAIT, DRAIN} state_t;
    state_t state;

    logic [NENTRIES-1:0] valid, pending, locked, dirty;
    logic [ADDR_W-1:0]   tag  [NENTRIES];
    logic [DATA_W-1:0]   data [NENTRIES];
    logic [IDX_W-1:0]    rr, vic;
    logic [ADDR_W-1:0]   fill_addr;
    logic                drain_pend;

    logic                lookup, hit_ok, match_found;
    logic [IDX_W-1:0]    match_idx;
    logic                victim_found;
    logic [IDX_W-1:0]    victim_idx, probe;
    logic                wr_found;
    logic [IDX_W-1:0]    wr_idx;
    logic                drain_found;
    logic [IDX_W-1:0]    drain_idx;
    logic                go_drain, miss_latch;

    // A pending entry already owns its new tag, so a repeat lookup stalls instead of re-missing.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        wr_found    = 1'b0;
        wr_idx      = '0;
        drain_found = 1'b0;
        drain_idx   = '0;
        for (int unsigned i = 0; i < NENTRIES; i++) begin
            if (!match_found && (valid[i] || pending[i]) && tag[i] == rd_addr) begin
                match_found = 1'b1;
                match_idx   = IDX_W'(i);
            end
            if (!wr_found && valid[i] && locked[i] && tag[i] == wr_addr) begin
                wr_found = 1'b1;
                wr_idx   = IDX_W'(i);
            end
            if (!drain_found && valid[i] && dirty[i]) begin
                drain_found = 1'b1;
                drain_idx   = IDX_W'(i);
            end
        end
        lookup  = rd_valid && !flush;
        hit_ok  = match_found && valid[match_idx] && !locked[match_idx] && !pending[match_idx];
        rd_hit  = lookup && hit_ok;
        rd_data = rd_hit ? data[match_idx] : '0;
        stall   = lookup && !hit_ok;
    end

    always_comb begin
        victim_found = 1'b0;
        victim_idx   = '0;
        probe        = '0;
        for (int unsigned k = 0; k < NENTRIES; k++) begin
            probe = rr + IDX_W'(k);
            if (!victim_found && !pending[probe] && (!valid[probe] || !locked[probe])) begin
                victim_found = 1'b1;
                victim_idx   = probe;
            end
        end
        go_drain   = drain || drain_pend;
        miss_latch = (state == IDLE) && !go_drain && lookup && !match_found && victim_found;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= '0;
            pending    <= '0;
            locked     <= '0;
            dirty      <= '0;
            rr         <= '0;
            vic        <= '0;
            fill_addr  <= '0;
            drain_pend <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            drain_done <= 1'b0;
        end else begin
            drain_done <= 1'b0;
            if (drain && (state == EVICT || state == FILL || state == WAIT))
                drain_pend <= 1'b1;
            if (rd_hit && rd_lock)
                locked[match_idx] <= 1'b1;
            if (wr_en && wr_found) begin
                data[wr_idx]   <= wr_data;
                locked[wr_idx] <= 1'b0;
                dirty[wr_idx]  <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (go_drain) begin
                        drain_pend <= 1'b0;
                        state      <= DRAIN;
                    end else if (miss_latch) begin
                        vic                 <= victim_idx;
                        rr                  <= victim_idx + IDX_W'(1);
                        fill_addr           <= rd_addr;
                        tag[victim_idx]     <= rd_addr;
                        valid[victim_idx]   <= 1'b0;
                        pending[victim_idx] <= 1'b1;
                        mem_req             <= 1'b1;
                        if (valid[victim_idx] && dirty[victim_idx]) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= tag[victim_idx];
                            mem_wdata <= data[victim_idx];
                            state     <= EVICT;
                        end else begin
                            mem_we   <= 1'b0;
                            mem_addr <= rd_addr;
                            state    <= FILL;
                        end
                    end
                end
                EVICT: begin
                    if (mem_gnt) begin
                        dirty[vic] <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_addr   <= fill_addr;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        data[vic]    <= mem_rdata;
                        valid[vic]   <= 1'b1;
                        pending[vic] <= 1'b0;
                        dirty[vic]   <= 1'b0;
                        locked[vic]  <= 1'b0;
                        state        <= IDLE;
                    end
                end
                DRAIN: begin
                    // Dirty clears at issue so a writeback landing mid-request re-dirties the entry.
                    if (mem_req) begin
                        if (mem_gnt) begin
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                        end
                    end else if (!drain_found) begin
                        drain_done <= 1'b1;
                        state      <= IDLE;
                    end else if (!locked[drain_idx]) begin
                        mem_req          <= 1'b1;
                        mem_we           <= 1'b1;
                        mem_addr         <= tag[drain_idx];
                        mem_wdata        <= data[drain_idx];
                        dirty[drain_idx] <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cell_cache.sv
// Bench for cell_cache: directed scenarios plus randomized traffic against a tape-memory model.
module tb_cell_cache;
    localparam int NE = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_valid = 1'b0, rd_lock = 1'b0, flush = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_hit, stall;
    logic [DW-1:0] rd_data;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          drain = 1'b0;
    logic          drain_done;

    always #5 clk = ~clk;

    cell_cache #(.NENTRIES(NE), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_lock(rd_lock), .flush(flush),
        .rd_hit(rd_hit), .rd_data(rd_data), .stall(stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .drain(drain), .drain_done(drain_done)
    );

    int unsigned n_checks = 0, n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Tape memory and the architecturally visible value of every cell.
    logic [DW-1:0] mem_m  [65536];
    logic [DW-1:0] shadow [65536];

    typedef struct { logic [AW-1:0] a; int unsigned due; } lk_t;
    lk_t          lockq[$];
    logic [31:0]  wlog[$];

    int unsigned  cyc = 0, refused = 0, gnt_need = 0, hold_cfg = 0, lat_cfg = 2, rd_due = 0;
    int unsigned  done_cnt = 0;
    bit           rand_gnt = 0, spurious = 0, track = 0, rd_out = 0, hold_prev = 0;
    logic [AW-1:0] rd_addr_q = '0;
    logic [33:0]  prev_bus = '0;
    logic         s_hit = 0, s_stall = 0, s_req = 0, s_we = 0, s_gnt = 0, s_done = 0;
    logic [DW-1:0] s_data = '0, s_wdata = '0;
    logic [AW-1:0] s_addr = '0;

    task automatic step();
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = DW'($urandom);
        if (!rst) begin
            if (mem_req && refused >= gnt_need) mem_gnt = 1'b1;
            if (rd_out && cyc == rd_due) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_m[rd_addr_q];
                rd_out     = 0;
            end else if (spurious && !rd_out && $urandom_range(0, 15) == 0) begin
                mem_rvalid = 1'b1;
            end
        end
        #1;
        if (hold_prev) check_eq("mem_hold", 64'({mem_req, mem_we, mem_addr, mem_wdata}), 64'(prev_bus));
        if (!rd_valid) check_eq("idle_quiet", 64'({rd_hit, stall}), 64'(0));
        else if (flush) check_eq("flush_quiet", 64'({rd_hit, stall}), 64'(0));
        else check_eq("hit_xor_stall", 64'(rd_hit ^ stall), 64'(1));
        if (rd_hit) check_eq("rd_data", 64'(rd_data), 64'(shadow[rd_addr]));
        if (mem_gnt) begin
            if (mem_we) begin
                mem_m[mem_addr] = mem_wdata;
                wlog.push_back({mem_addr, mem_wdata});
            end else begin
                rd_out    = 1;
                rd_addr_q = mem_addr;
                rd_due    = cyc + (rand_gnt ? $urandom_range(1, 4) : lat_cfg);
            end
            refused  = 0;
            gnt_need = rand_gnt ? $urandom_range(0, 2) : hold_cfg;
        end else if (mem_req && !rst) begin
            refused++;
        end
        hold_prev = !rst && mem_req && !mem_gnt;
        prev_bus  = {mem_req, mem_we, mem_addr, mem_wdata};
        if (track && rd_hit && rd_lock) lockq.push_back('{rd_addr, cyc + $urandom_range(1, 4)});
        if (wr_en) shadow[wr_addr] = wr_data;
        if (drain_done) done_cnt++;
        s_hit = rd_hit; s_stall = stall; s_data = rd_data; s_req = mem_req; s_we = mem_we;
        s_addr = mem_addr; s_wdata = mem_wdata; s_gnt = mem_gnt; s_done = drain_done;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; rd_valid = 0; rd_lock = 0; flush = 0; wr_en = 0; drain = 0;
        rd_out = 0; hold_prev = 0; refused = 0; gnt_need = hold_cfg;
        lockq.delete();
        step();
        step();
        rst = 1'b0;
        for (int a = 0; a < 65536; a++) shadow[a] = mem_m[a];
        step();
        check_eq("reset_flags", 64'({s_hit, s_stall, s_req, s_we, s_done}), 64'(0));
        check_eq("reset_addr", 64'(s_addr), 64'(0));
        check_eq("reset_wdata", 64'(s_wdata), 64'(0));
        check_eq("reset_rdata", 64'(s_data), 64'(0));
    endtask

    task automatic wait_hit(input logic [AW-1:0] a, input logic lk);
        bit got = 0;
        rd_valid = 1; rd_addr = a; rd_lock = lk; flush = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            step();
            got = s_hit;
        end
        if (!got) check_eq("hit_timeout", 64'(s_hit), 64'(1));
        rd_valid = 0; rd_lock = 0;
    endtask

    task automatic write_back(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        step();
        wr_en = 0;
    endtask

    initial begin
        bit seen;
        for (int a = 0; a < 65536; a++) mem_m[a] = DW'(a * 7 + 3) ^ 16'h5a00;
        mem_m[16'h0010] = 16'h0007;
        do_reset();

        // Clean miss: stall cycles 0-3, hit on cycle 4.
        rd_valid = 1; rd_addr = 16'h0010; rd_lock = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            check_eq("t1_stall", 64'(s_stall), 64'(1));
            check_eq("t1_req", 64'(s_req), 64'(c == 1));
            if (s_req) check_eq("t1_fill_addr", 64'({s_we, s_addr}), 64'({1'b0, 16'h0010}));
        end
        step();
        check_eq("t1_hit", 64'({s_hit, s_data}), 64'({1'b1, 16'h0007}));

        // Lock on hit, locked re-lookup stalls, writeback lands.
        rd_lock = 1;
        step();
        check_eq("t2_lock_hit", 64'({s_hit, s_data}), 64'({1'b1, 16'h0007}));
        rd_lock = 0;
        step();
        check_eq("t2_locked_stall", 64'(s_stall), 64'(1));
        rd_valid = 0;
        write_back(16'h0010, 16'h0008);
        rd_valid = 1;
        step();
        check_eq("t2_after_wb", 64'({s_hit, s_data}), 64'({1'b1, 16'h0008}));
        rd_valid = 0;

        // Fill remaining ways, then a miss evicts the dirty entry before filling.
        wait_hit(16'h0011, 0);
        wait_hit(16'h0012, 0);
        wait_hit(16'h0013, 0);
        rd_valid = 1; rd_addr = 16'h0014;
        step();
        check_eq("t3_miss_stall", 64'({s_stall, s_req}), 64'({1'b1, 1'b0}));
        step();
        check_eq("t3_evict", 64'({s_req, s_we, s_addr, s_wdata}), 64'({1'b1, 1'b1, 16'h0010, 16'h0008}));
        step();
        check_eq("t3_fill", 64'({s_req, s_we, s_addr}), 64'({1'b1, 1'b0, 16'h0014}));
        wait_hit(16'h0014, 0);
        check_eq("t3_mem_written", 64'(mem_m[16'h0010]), 64'(16'h0008));

        // All ways locked: miss waits without a request until one writeback frees a way.
        wait_hit(16'h0014, 1);
        wait_hit(16'h0011, 1);
        wait_hit(16'h0012, 1);
        wait_hit(16'h0013, 1);
        rd_valid = 1; rd_addr = 16'h0020;
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq("t4_blocked", 64'({s_stall, s_req}), 64'({1'b1, 1'b0}));
        end
        wr_en = 1; wr_addr = 16'h0012; wr_data = 16'h1234;
        step();
        wr_en = 0;
        check_eq("t4_wb_cycle_stall", 64'(s_stall), 64'(1));
        wait_hit(16'h0020, 0);
        check_eq("t4_evicted", 64'(mem_m[16'h0012]), 64'(16'h1234));
        write_back(16'h0014, shadow[16'h0014] + 16'h0001);
        write_back(16'h0011, shadow[16'h0011] - 16'h0001);
        write_back(16'h0013, shadow[16'h0013] + 16'h0001);

        // Flush while the fill for 0x30 is outstanding; the fill still installs unlocked.
        rd_valid = 1; rd_addr = 16'h0030; seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            step();
            seen = s_req && !s_we && s_gnt && (s_addr == 16'h0030);
        end
        check_eq("t5_fill_grant", 64'(seen), 64'(1));
        flush = 1;
        step();
        check_eq("t5_flush", 64'({s_hit, s_stall}), 64'(0));
        flush = 0; rd_valid = 0;
        step();
        rd_valid = 1; rd_lock = 1;
        step();
        check_eq("t5_hit0", 64'({s_hit, s_data}), 64'({1'b1, shadow[16'h0030]}));
        // Writeback and lookup of the same cell in one cycle: stall, then hit new value.
        rd_lock = 0; wr_en = 1; wr_addr = 16'h0030; wr_data = 16'h4321;
        step();
        wr_en = 0;
        check_eq("t5_collide", 64'(s_stall), 64'(1));
        step();
        check_eq("t5_after", 64'({s_hit, s_data}), 64'({1'b1, 16'h4321}));
        rd_valid = 0;

        // Drain two dirty entries with a slow arbiter: index order, one done pulse.
        do_reset();
        wait_hit(16'h0050, 0);
        wait_hit(16'h0051, 0);
        wait_hit(16'h0052, 0);
        wait_hit(16'h0052, 1);
        write_back(16'h0052, 16'hbeef);
        wait_hit(16'h0050, 1);
        write_back(16'h0050, 16'hcafe);
        hold_cfg = 3; gnt_need = 3; wlog.delete(); done_cnt = 0;
        drain = 1;
        step();
        drain = 0; seen = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
            step();
            seen = s_done;
        end
        for (int c = 0; c < 5; c++) step();
        check_eq("t6_done_once", 64'(done_cnt), 64'(1));
        check_eq("t6_nwrites", 64'(wlog.size()), 64'(2));
        if (wlog.size() == 2) begin
            check_eq("t6_write0", 64'(wlog[0]), 64'({16'h0050, 16'hcafe}));
            check_eq("t6_write1", 64'(wlog[1]), 64'({16'h0052, 16'hbeef}));
        end
        hold_cfg = 0; gnt_need = 0;

        // Randomized traffic over a small address window to force constant eviction.
        rand_gnt = 1; spurious = 1; track = 1;
        for (int c = 0; c < 2000; c++) begin
            wr_en = 0;
            if (lockq.size() > 0 && lockq[0].due <= cyc) begin
                wr_en   = 1;
                wr_addr = lockq[0].a;
                wr_data = shadow[lockq[0].a] + (($urandom_range(0, 1) == 1) ? 16'h0001 : 16'hffff);
                void'(lockq.pop_front());
            end
            if (!(rd_valid && s_stall && !flush)) begin
                rd_valid = ($urandom_range(0, 3) != 0);
                rd_addr  = 16'h0040 + AW'($urandom_range(0, 7));
                rd_lock  = $urandom_range(0, 1) == 1;
            end
            flush = rd_valid && ($urandom_range(0, 9) == 0);
            drain = ($urandom_range(0, 63) == 0);
            step();
        end
        rd_valid = 0; flush = 0; drain = 0; rd_lock = 0;
        for (int c = 0; c < 50 && lockq.size() > 0; c++) begin
            wr_en = 0;
            if (lockq[0].due <= cyc) begin
                wr_en   = 1;
                wr_addr = lockq[0].a;
                wr_data = shadow[lockq[0].a] ^ 16'h00f0;
                void'(lockq.pop_front());
            end
            step();
        end
        wr_en = 0; spurious = 0;
        for (int c = 0; c < 10; c++) step();
        drain = 1;
        step();
        drain = 0; seen = 0;
        for (int c = 0; c < 300 && !seen; c++) begin
            step();
            seen = s_done;
        end
        check_eq("final_drain_done", 64'(seen), 64'(1));
        for (int a = 16'h0040; a <= 16'h0047; a++)
            check_eq("final_mem", 64'(mem_m[a]), 64'(shadow[a]));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/cell_cache.md
# cell_cache

Per-core tape-cell cache for the threadbrain pipeline. It generalises the select-stage register lookup into an N-entry, write-back, lockable cache over the shared tape memory. It serves cell lookups for `+`/`-`/`[` instructions and locks cells that are being modified until the execute stage writes them back. It fills misses and evicts dirty victims through a shared-memory request/grant port, and drains all dirty cells on demand (end of thread, context switch).

## Interface
- `NENTRIES`, 4: cache entries (≥2, power of two).
- `ADDR_W`, 16: tape address width.
- `DATA_W`, 16: cell width.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rd_valid` input 1: lookup request this cycle.
- `rd_addr` input ADDR_W: cell address (tape ptr).
- `rd_lock` input 1: lock cell on hit (`+`/`-`); 0 for `[`/`]` reads.
- `flush` input 1: branch taken; cancel this cycle's lookup.
- `rd_hit` output 1: `rd_data` is valid this cycle.
- `rd_data` output DATA_W: cell value.
- `stall` output 1: lookup cannot complete; upstream holds its request.
- `wr_en` input 1: execute-stage writeback; unlocks entry, marks dirty.
- `wr_addr` input ADDR_W; `wr_data` input DATA_W.
- `mem_req` output 1; `mem_we` output 1; `mem_addr` output ADDR_W; `mem_wdata` output DATA_W.
- `mem_gnt` input 1: arbiter accepts the request this cycle.
- `mem_rvalid` input 1; `mem_rdata` input DATA_W: read response, arbitrary latency ≥1.
- `drain` input 1: pulse; write back all dirty entries.
- `drain_done` output 1: one-cycle pulse when drain completes.

## Operation
- Entry state: valid, pending (fill outstanding), locked, dirty, tag[ADDR_W], data[DATA_W].
- Lookup is combinational against the pre-edge state.
  - Valid, unlocked tag match: `rd_hit`=1 and `rd_data`=entry data. If `rd_lock`, locked is set at the edge.
  - Match on a locked or pending entry: `stall`=1.
  - No match: `stall`=1. If the FSM is IDLE, a miss is latched: victim chosen, entry marked pending with the new tag.
- `flush`=1 forces `rd_hit`=0 and `stall`=0, and no miss is latched. Any fill already in flight still completes and installs unlocked.
- Victim: round-robin pointer, first entry at or after it that is invalid or (valid and not locked and not pending). The pointer advances past the chosen entry. If every entry is locked or pending, `stall` stays 1 and no miss is latched.
- FSM states and transitions:
  - IDLE → EVICT if the victim is dirty, else → FILL.
  - EVICT: `mem_req`=1, `mem_we`=1, victim's old address and data. On `mem_gnt`, dirty is cleared and the FSM → FILL.
  - FILL: `mem_req`=1, `mem_we`=0, new tag. On `mem_gnt` → WAIT.
  - WAIT: on `mem_rvalid`, data is installed (valid=1, pending=0, dirty=0, locked=0) and the FSM → IDLE.
  - DRAIN: entered from IDLE on `drain`. Each dirty unlocked entry is written back in index order, one per grant. `drain_done` pulses and the FSM → IDLE. Locked entries are waited on until unlocked. A `drain` pulse arriving mid-miss is held until IDLE. Lookups during DRAIN hit normally; misses stall.
- `wr_en`: the matching locked entry takes `wr_data`, locked=0, dirty=1. A `wr_en` with no locked match is ignored.
- Output stability: `mem_*` outputs are held stable while `mem_req`=1 and `mem_gnt`=0.
- Arithmetic: addresses compare full ADDR_W; no wrap handling is needed.

## Timing
- Reset values: all entries invalid/unlocked/clean, FSM IDLE, round-robin pointer 0. `rd_hit`, `stall`, `mem_req`, `mem_we`, `drain_done` are 0; `rd_data`, `mem_addr`, `mem_wdata` are 0. Dirty data is discarded. A fill response arriving after reset is ignored.
- Hit latency: 0 cycles (same-cycle `rd_data`).
- Clean-miss latency: `mem_req` rises the cycle after the miss cycle. The entry installs on the `mem_rvalid` edge, and the held request hits the following cycle. With immediate grant and 2-cycle response, a miss at cycle 0 hits at cycle 4.
- Dirty miss: adds ≥1 cycle (the EVICT grant) before FILL.
- Writeback/lookup collision: `wr_en` and a lookup of the same address in one cycle → stall that cycle, hit the next (no bypass).
- `mem_rvalid` is only accepted in WAIT; at any other time it is ignored.

## Test plan
- Reset, then `rd_addr`=0x0010 with `mem_rdata`=0x0007 and 2-cycle latency → stall cycles 0–3, `rd_hit`, `rd_data`=0x0007 at cycle 4; `mem_we`=0 throughout.
- Hit with lock on 0x0010, then re-lookup 0x0010 → stall. Then `wr_en` with 0x0008 → next lookup hits 0x0008, entry dirty.
- NENTRIES=4: fill 0x10, 0x11, 0x12, 0x13 and dirty 0x10, then miss 0x14 → EVICT writes addr 0x10 data 0x0008, then FILL 0x14.
- Lock all 4 entries, miss on 0x20 → `stall` held, `mem_req`=0. `wr_en` on one entry → eviction/fill proceeds.
- `flush` during WAIT for 0x30 → `stall`=0 same cycle; the fill installs 0x30 unlocked; a later lookup of 0x30 hits at 0 latency.
- Two dirty entries, `drain`, `mem_gnt` low for 3 cycles → `mem_*` held stable, two writes in index order, then `drain_done` pulses once.
